irr_arbiter_sel: RTL and testbench

Packet-level round-robin arbiter for the AXI Stream switch output port. It watches the per-input request vector, grants one input at a time, and drives the binary select into the output multiplexer. It also drives a one-hot grant that gates tvalid/tready routing. A grant is held until the muxed stream completes a packet (tvalid & tready & tlast), then priority rotates to the input after the one just served.

---
 rtl/irr_arbiter_pkg.sv | 22 ++
 rtl/irr_arbiter_prio.sv | 43 ++++
 rtl/irr_arbiter_sel.sv | 103 ++++++++++
 tb/tb_irr_arbiter_sel.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irr_arbiter_pkg.sv
// ============================================================================
// Module  : irr_arbiter_pkg
// Purpose : Shared state encoding and index helper for the packet arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package irr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Wrap-around increment against an arbitrary (non power-of-two) modulus.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned amount);
        return (idx == amount - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irr_arbiter_prio.sv
// ============================================================================
// Module  : irr_arbiter_prio
// Purpose : Combinational rotating priority encoder (search starts at ptr).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irr_arbiter_prio #(
    parameter int AMOUNT_IN = 10,
    parameter int SEL_W     = $clog2(AMOUNT_IN)
) (
    input  logic [AMOUNT_IN-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     winner,
    output logic                 any_req
);

    logic [2*AMOUNT_IN-1:0] dbl;
    logic [AMOUNT_IN-1:0]   rot;
    logic [SEL_W-1:0]       off;
    logic [SEL_W:0]         sum;

    // Rotating the doubled vector right by ptr puts index ptr at bit 0.
    assign dbl = {req, req};
    assign rot = AMOUNT_IN'(dbl >> ptr);

    always_comb begin
        off = '0;
        for (int i = AMOUNT_IN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign winner  = (sum >= (SEL_W + 1)'(AMOUNT_IN)) ? SEL_W'(sum - (SEL_W + 1)'(AMOUNT_IN))
                                                      : sum[SEL_W-1:0];
    assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/irr_arbiter_sel.sv
// ============================================================================
// Module  : irr_arbiter_sel
// Purpose : Packet-level round-robin arbiter driving mux select and one-hot grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irr_arbiter_sel
    import irr_arbiter_pkg::*;
#(
    parameter int AMOUNT_IN = 10,
    parameter int SEL_W     = $clog2(AMOUNT_IN)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [AMOUNT_IN-1:0] req_i,
    input  logic                 out_tvalid_i,
    input  logic                 out_tready_i,
    input  logic                 out_tlast_i,
    output logic [SEL_W-1:0]     sel_o,
    output logic [AMOUNT_IN-1:0] grant_o,
    output logic                 busy_o
);

    state_t               state;
    state_t               state_nxt;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     ptr_nxt;
    logic [SEL_W-1:0]     sel_nxt;
    logic [AMOUNT_IN-1:0] grant_nxt;
    logic                 busy_nxt;
    logic [SEL_W-1:0]     winner;
    logic                 any_req;
    logic                 pkt_done;

    irr_arbiter_prio #(
        .AMOUNT_IN (AMOUNT_IN),
        .SEL_W     (SEL_W)
    ) u_prio (
        .req     (req_i),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign pkt_done = out_tvalid_i & out_tready_i & out_tlast_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            ptr     <= '0;
            sel_o   <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            sel_o   <= sel_nxt;
            grant_o <= grant_nxt;
            busy_o  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)  state_nxt = BUSY;
            BUSY:    if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant stays frozen while BUSY; requests are only looked at in IDLE.
    always_comb begin
        ptr_nxt   = ptr;
        sel_nxt   = sel_o;
        grant_nxt = grant_o;
        busy_nxt  = busy_o;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt   = winner;
                    grant_nxt = AMOUNT_IN'(1) << winner;
                    busy_nxt  = 1'b1;
                end
            end
            BUSY: begin
                if (pkt_done) begin
                    ptr_nxt   = SEL_W'(next_idx(32'(sel_o), AMOUNT_IN));
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_irr_arbiter_sel.sv
// ============================================================================
// Module  : tb_irr_arbiter_sel
// Purpose : Self-checking bench for irr_arbiter_sel against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irr_arbiter_sel;

    localparam int N = 10;

    logic         clk;
    logic         rstn;
    logic [N-1:0] req;
    logic         tv;
    logic         tr;
    logic         tl;
    logic [3:0]   sel;
    logic [N-1:0] grant;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_ptr  = 0;
    int m_sel  = 0;
    bit m_busy = 0;

    irr_arbiter_sel #(.AMOUNT_IN(N)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_i        (req),
        .out_tvalid_i (tv),
        .out_tready_i (tr),
        .out_tlast_i  (tl),
        .sel_o        (sel),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_busy) g[m_sel] = 1'b1;
        return g;
    endfunction

    task automatic model_tick();
        if (!m_busy) begin
            if (req != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (req[(m_ptr + k) % N]) begin
                        m_sel  = (m_ptr + k) % N;
                        m_busy = 1;
                        break;
                    end
                end
            end
        end else if (tv && tr && tl) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % N;
        end
    endtask

    task automatic cyc(input logic [N-1:0] rq, input logic v, input logic r, input logic l);
        req = rq; tv = v; tr = r; tl = l;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        req = '0; tv = 0; tr = 0; tl = 0;
        rstn = 1'b0;
        m_busy = 0; m_ptr = 0; m_sel = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (sel !== 4'd0 || grant !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: sel=%0d grant=%h busy=%b, want 0/000/0", sel, grant, busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(10'b0000000101, 0, 0, 0);
        total++;
        if (sel !== 4'd0 || grant !== 10'h001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_grant: sel=%0d grant=%h busy=%b, want 0/001/1", sel, grant, busy);
        end
        cyc(10'b0000000101, 1, 1, 1);
        total++;
        if (grant !== 10'h000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_release: grant=%h busy=%b, want 000/0", grant, busy);
        end
        cyc(10'b0000000101, 0, 0, 0);
        total++;
        if (sel !== 4'd2 || grant !== 10'h004 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_next: sel=%0d grant=%h busy=%b, want 2/004/1", sel, grant, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 11; p++) begin
            cyc(10'h3FF, 0, 0, 0);
            total++;
            if (sel !== 4'(p % N) || grant !== (10'h001 << (p % N)) || busy !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant[%0d]: sel=%0d grant=%h busy=%b, want sel %0d", p, sel, grant, busy, p % N);
            end
            cyc(10'h3FF, 1, 1, 0);
            cyc(10'h3FF, 1, 1, 0);
            total++;
            if (busy !== 1'b1 || sel !== 4'(p % N)) begin
                bad++;
                $display("FAIL rr_hold[%0d]: sel=%0d busy=%b, want %0d/1", p, sel, busy, p % N);
            end
            cyc(10'h3FF, 1, 1, 1);
            total++;
            if (busy !== 1'b0 || grant !== '0) begin
                bad++;
                $display("FAIL rr_bubble[%0d]: grant=%h busy=%b, want 000/0", p, grant, busy);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc(10'h010, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(10'h010, 1, 0, 1);
            total++;
            if (busy !== 1'b1 || sel !== 4'd4 || grant !== 10'h010) begin
                bad++;
                $display("FAIL stall[%0d]: sel=%0d grant=%h busy=%b, want 4/010/1", i, sel, grant, busy);
            end
        end
        cyc(10'h010, 0, 1, 1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_novalid: busy=%b, want 1", busy);
        end
        cyc(10'h010, 1, 1, 1);
        total++;
        if (busy !== 1'b0 || grant !== '0) begin
            bad++;
            $display("FAIL stall_release: grant=%h busy=%b, want 000/0", grant, busy);
        end
    endtask

    task automatic test_drop();
        do_reset();
        cyc(10'h080, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(10'h100, 1, 1, 0);
            total++;
            if (sel !== 4'd7 || grant !== 10'h080 || busy !== 1'b1) begin
                bad++;
                $display("FAIL drop_hold[%0d]: sel=%0d grant=%h, want 7/080", i, sel, grant);
            end
        end
        cyc(10'h100, 1, 1, 1);
        cyc(10'h100, 0, 0, 0);
        total++;
        if (sel !== 4'd8 || grant !== 10'h100 || busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_next: sel=%0d grant=%h, want 8/100", sel, grant);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(10'h100, 0, 0, 0);
        cyc(10'h100, 1, 1, 1);
        cyc(10'h002, 0, 0, 0);
        total++;
        if (sel !== 4'd1 || grant !== 10'h002) begin
            bad++;
            $display("FAIL wrap_grant: sel=%0d grant=%h, want 1/002", sel, grant);
        end
        cyc(10'h002, 1, 1, 1);
        cyc(10'h3FF, 0, 0, 0);
        total++;
        if (sel !== 4'd2 || grant !== 10'h004) begin
            bad++;
            $display("FAIL wrap_ptr: sel=%0d grant=%h, want 2/004", sel, grant);
        end
    endtask

    task automatic test_idle_handshake();
        do_reset();
        cyc(10'h000, 1, 1, 1);
        total++;
        if (busy !== 1'b0 || grant !== '0) begin
            bad++;
            $display("FAIL idle_hs: grant=%h busy=%b, want 000/0", grant, busy);
        end
        cyc(10'h3FF, 0, 0, 0);
        total++;
        if (sel !== 4'd0) begin
            bad++;
            $display("FAIL idle_hs_ptr: sel=%0d, want 0", sel);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(10'h008, 0, 0, 0);
        cyc(10'h008, 1, 1, 0);
        #2;
        rstn = 1'b0;
        m_busy = 0; m_ptr = 0; m_sel = 0;
        #1;
        total++;
        if (sel !== 4'd0 || grant !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: sel=%0d grant=%h busy=%b, want 0/000/0", sel, grant, busy);
        end
        req = '0; tv = 0; tr = 0; tl = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(10'h3FF, 1, 1, 1);
        total++;
        if (sel !== 4'd0 || grant !== 10'h001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL async_regrant: sel=%0d grant=%h busy=%b, want 0/001/1", sel, grant, busy);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rq = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            cyc(rq, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
            total++;
            if (busy !== m_busy || grant !== m_grant() || (m_busy && sel !== 4'(m_sel))) begin
                bad++;
                $display("FAIL random[%0d]: sel=%0d grant=%h busy=%b, want sel %0d grant %h busy %b",
                         i, sel, grant, busy, m_sel, m_grant(), m_busy);
            end
        end
    endtask

    initial begin
        rstn = 1'b1;
        req = '0; tv = 0; tr = 0; tl = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_drop();
        test_wrap();
        test_idle_handshake();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
